// File: rtl/core_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_ctrl_pkg
// Description : Shared types and constants for the core front-end control:
//               sequencer state encoding, sticky fault cause codes and a
//               helper that keeps the first recorded fault cause.
// Revision    : 1.0 - initial release
// ============================================================================
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_e;

    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_HALT     = 2'd1;
    localparam logic [1:0] FAULT_MISALIGN = 2'd2;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'd3;

    // Fault cause is sticky: once a cause is recorded, later causes are dropped.
    function automatic logic [1:0] first_fault(input logic [1:0] cur,
                                               input logic [1:0] cause);
        return (cur != FAULT_NONE) ? cur : cause;
    endfunction

endpackage : core_ctrl_pkg
`default_nettype wire

// File: rtl/bus_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : bus_wait_timer
// Description : Counts cycles spent waiting for a bus acknowledge and flags
//               the last permitted wait cycle.
//   clock   in  system clock, rising edge
//   reset   in  synchronous active-high reset
//   clear   in  force count to zero (while not waiting on a bus)
//   enable  in  advance count by one (waiting and no ack this cycle)
//   expired out count has reached TIMEOUT_CYCLES-1
// Revision    : 1.0 - initial release
// ============================================================================
module bus_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] c_wait_limit = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = 8'd0;
        end else if (enable) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == c_wait_limit);

endmodule : bus_wait_timer
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Multi-cycle front-end control FSM. Fetches at pc_value,
//               holds the instruction for decode, stalls on data accesses,
//               pulses pc_en once per retired instruction and stops on
//               halt, misaligned-PC or bus-timeout faults.
//   clock/reset             clock and synchronous active-high reset
//   pc_value                current PC from the pc block
//   imem_req/addr/ack/rdata instruction fetch handshake
//   instr/instr_valid       latched instruction for the decoder
//   is_load/store/halt      decoder classification, sampled in DECODE
//   dmem_req/dmem_ack       data access handshake
//   pc_en/rf_commit         retire strobes (WB only)
//   halted/fault            sticky stop flag and cause
//   instret                 retired-instruction counter
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int INSTRET_W      = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          pc_value,
    output logic                 imem_req,
    output logic [31:0]          imem_addr,
    input  logic                 imem_ack,
    input  logic [31:0]          imem_rdata,
    output logic [31:0]          instr,
    output logic                 instr_valid,
    input  logic                 is_load,
    input  logic                 is_store,
    input  logic                 is_halt,
    output logic                 dmem_req,
    input  logic                 dmem_ack,
    output logic                 pc_en,
    output logic                 rf_commit,
    output logic                 halted,
    output logic [1:0]           fault,
    output logic [INSTRET_W-1:0] instret
);

    import core_ctrl_pkg::*;

    localparam logic [INSTRET_W-1:0] c_one = {{(INSTRET_W-1){1'b0}}, 1'b1};

    state_e                 state_q,   state_d;
    logic [31:0]            instr_q,   instr_d;
    logic [INSTRET_W-1:0]   instret_q, instret_d;
    logic [1:0]             fault_q,   fault_d;

    logic w_misaligned;
    logic w_wait_clear;
    logic w_wait_en;
    logic w_wait_expired;

    assign w_misaligned = (pc_value[1:0] != 2'b00);

    // Counter only runs while a bus request is outstanding; any other state
    // holds it at zero so it starts fresh on entry to FETCH or MEM.
    assign w_wait_clear = (state_q != FETCH) && (state_q != MEM);
    assign w_wait_en    = ((state_q == FETCH) && !imem_ack) ||
                          ((state_q == MEM)   && !dmem_ack);

    bus_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_bus_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (w_wait_clear),
        .enable  (w_wait_en),
        .expired (w_wait_expired)
    );

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        instret_d = instret_q;
        fault_d   = fault_q;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (w_misaligned) begin
                    state_d = HALT;
                    fault_d = first_fault(fault_q, FAULT_MISALIGN);
                end else if (imem_ack) begin
                    // An ack on the final wait cycle still completes normally.
                    instr_d = imem_rdata;
                    state_d = DECODE;
                end else if (w_wait_expired) begin
                    state_d = HALT;
                    fault_d = first_fault(fault_q, FAULT_TIMEOUT);
                end
            end
            DECODE: begin
                if (is_halt) begin
                    state_d = HALT;
                    fault_d = first_fault(fault_q, FAULT_HALT);
                end else if (is_load || is_store) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                if (dmem_ack) begin
                    state_d = WB;
                end else if (w_wait_expired) begin
                    state_d = HALT;
                    fault_d = first_fault(fault_q, FAULT_TIMEOUT);
                end
            end
            WB: begin
                instret_d = instret_q + c_one;
                state_d   = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            instr_q   <= 32'd0;
            instret_q <= '0;
            fault_q   <= FAULT_NONE;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            instret_q <= instret_d;
            fault_q   <= fault_d;
        end
    end

    // Moore outputs; the misalignment term only suppresses an illegal fetch.
    assign imem_req    = (state_q == FETCH) && !w_misaligned;
    assign imem_addr   = pc_value;
    assign dmem_req    = (state_q == MEM);
    assign pc_en       = (state_q == WB);
    assign rf_commit   = (state_q == WB);
    assign instr_valid = (state_q == DECODE) || (state_q == MEM) || (state_q == WB);
    assign halted      = (state_q == HALT);
    assign instr       = instr_q;
    assign fault       = fault_q;
    assign instret     = instret_q;

endmodule : fetch_sequencer
`default_nettype wire
